decode: RTL and testbench

- Second pipeline stage. Consumes instr/PC/pipeline_valid from fetch and produces a registered, fully decoded RV32I instruction bundle for execute.
- Owns a register scoreboard that blocks RAW hazards, and generates the stall back to fetch.
- Honours the same flush used by fetch.
- Latency is one clock from an accepted fetch beat to out_valid.

---
 rtl/decode_pkg.sv | 42 ++++
 rtl/decode_scoreboard.sv | 47 ++++
 rtl/decode.sv | 225 ++++++++++++++++++++++
 tb/tb_decode.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared constants for the RV32I decode stage.
//   - address / instruction sizes (MSB index, as used by fetch)
//   - register index width
//   - major opcode constants and the instruction-class encoding
package decode_pkg;

  localparam int ADDR_SIZE  = 31;
  localparam int INSTR_SIZE = 31;
  localparam int CLS_W      = 4;
  localparam int REG_W      = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [CLS_W-1:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OP_IMM  = 4'd7,
    CLS_OP      = 4'd8,
    CLS_SYSTEM  = 4'd9,
    CLS_ILLEGAL = 4'd15
  } instr_class_e;

  // funct3 values for which OP_IMM is a shift and instr[30] selects SRAI.
  function automatic logic is_shift_imm(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: one busy bit per architectural register.
//   clk, reset            : clock, asynchronous active-high reset
//   i_set_en, i_set_rd    : mark a register busy (issued writer)
//   i_rel_valid, i_rel_rd : release a register (writer retired/squashed)
//   i_rs1, i_rs2          : source indices to query
//   o_rs1_busy/o_rs2_busy : busy state with this cycle's release bypassed
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_set_en,
  input  logic [REG_W-1:0] i_set_rd,
  input  logic             i_rel_valid,
  input  logic [REG_W-1:0] i_rel_rd,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  output logic             o_rs1_busy,
  output logic             o_rs2_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_eff;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Release is applied first so that a same-cycle set of the same index wins.
  // Bit 0 is forced clear: x0 is never a hazard.
  always_comb begin
    w_busy_eff = r_busy;
    if (i_rel_valid) w_busy_eff[i_rel_rd] = 1'b0;
    w_busy_eff[0] = 1'b0;
    w_busy_nxt = w_busy_eff;
    if (i_set_en) w_busy_nxt[i_set_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign o_rs1_busy = w_busy_eff[i_rs1];
  assign o_rs2_busy = w_busy_eff[i_rs2];

endmodule

// File: rtl/decode.sv
// decode: second pipeline stage. Decodes an RV32I instruction from fetch into
// a registered bundle for execute, blocking RAW hazards with a scoreboard.
//   clk, reset           : clock, asynchronous active-high reset
//   in_instr/in_PC       : instruction beat from fetch, valid on in_valid
//   stall_out            : combinational stall to fetch (beat not consumed)
//   flush                : squash the held bundle, refuse this beat
//   ex_stall             : execute cannot take a new bundle
//   out_*                : registered decoded bundle, valid on out_valid
//   rel_valid/rel_rd     : scoreboard release from writeback
module decode
  import decode_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CLASS_W  = CLS_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INSTR_SIZE:0]   in_instr,
  input  logic [ADDR_SIZE:0]    in_PC,
  input  logic                  in_valid,
  output logic                  stall_out,
  input  logic                  flush,
  input  logic                  ex_stall,
  output logic                  out_valid,
  output logic [ADDR_SIZE:0]    out_PC,
  output logic [CLASS_W-1:0]    out_class,
  output logic [2:0]            out_funct3,
  output logic                  out_alt,
  output logic [REG_W-1:0]      out_rs1,
  output logic [REG_W-1:0]      out_rs2,
  output logic [REG_W-1:0]      out_rd,
  output logic                  out_rd_write,
  output logic [31:0]           out_imm,
  input  logic                  rel_valid,
  input  logic [REG_W-1:0]      rel_rd
);

  instr_class_e        w_class;
  logic                w_uses_rs1;
  logic                w_uses_rs2;
  logic                w_has_rd;
  logic                w_alt;
  logic [31:0]         w_imm;
  logic [REG_W-1:0]    w_rs1;
  logic [REG_W-1:0]    w_rs2;
  logic [REG_W-1:0]    w_rd;
  logic                w_rd_write;
  logic                w_rs1_busy;
  logic                w_rs2_busy;
  logic                w_hazard;
  logic                w_hold;
  logic                w_accept;
  logic                w_set_en;

  logic                r_valid;
  logic [ADDR_SIZE:0]  r_pc;
  logic [CLASS_W-1:0]  r_class;
  logic [2:0]          r_funct3;
  logic                r_alt;
  logic [REG_W-1:0]    r_rs1;
  logic [REG_W-1:0]    r_rs2;
  logic [REG_W-1:0]    r_rd;
  logic                r_rd_write;
  logic [31:0]         r_imm;

  // Combinational decode. Every legal major opcode ends in 2'b11, so any
  // other low pair falls to the ILLEGAL default, as does an unknown opcode.
  always_comb begin
    w_class    = CLS_ILLEGAL;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_has_rd   = 1'b0;
    w_alt      = 1'b0;
    w_imm      = 32'd0;
    if (in_instr[1:0] == 2'b11) begin
      case (in_instr[6:0])
        OPC_LUI: begin
          w_class  = CLS_LUI;
          w_has_rd = 1'b1;
          w_imm    = {in_instr[31:12], 12'b0};
        end
        OPC_AUIPC: begin
          w_class  = CLS_AUIPC;
          w_has_rd = 1'b1;
          w_imm    = {in_instr[31:12], 12'b0};
        end
        OPC_JAL: begin
          w_class  = CLS_JAL;
          w_has_rd = 1'b1;
          w_imm    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
        end
        OPC_JALR: begin
          w_class    = CLS_JALR;
          w_uses_rs1 = 1'b1;
          w_has_rd   = 1'b1;
          w_imm      = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        OPC_BRANCH: begin
          w_class    = CLS_BRANCH;
          w_uses_rs1 = 1'b1;
          w_uses_rs2 = 1'b1;
          w_imm      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
        end
        OPC_LOAD: begin
          w_class    = CLS_LOAD;
          w_uses_rs1 = 1'b1;
          w_has_rd   = 1'b1;
          w_imm      = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        OPC_STORE: begin
          w_class    = CLS_STORE;
          w_uses_rs1 = 1'b1;
          w_uses_rs2 = 1'b1;
          w_imm      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
        OPC_OP_IMM: begin
          w_class    = CLS_OP_IMM;
          w_uses_rs1 = 1'b1;
          w_has_rd   = 1'b1;
          w_alt      = is_shift_imm(in_instr[14:12]) & in_instr[30];
          w_imm      = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        OPC_OP: begin
          w_class    = CLS_OP;
          w_uses_rs1 = 1'b1;
          w_uses_rs2 = 1'b1;
          w_has_rd   = 1'b1;
          w_alt      = in_instr[30];
        end
        OPC_SYSTEM: begin
          w_class  = CLS_SYSTEM;
          w_has_rd = 1'b1;
          w_imm    = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        default: ;
      endcase
    end
  end

  // Index fields are zeroed when the format does not carry them, so the
  // scoreboard queries x0 (never busy) for unused sources.
  assign w_rs1      = w_uses_rs1 ? in_instr[19:15] : '0;
  assign w_rs2      = w_uses_rs2 ? in_instr[24:20] : '0;
  assign w_rd       = w_has_rd   ? in_instr[11:7]  : '0;
  assign w_rd_write = w_has_rd && (w_rd != '0);

  decode_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .i_set_en    (w_set_en),
    .i_set_rd    (w_rd),
    .i_rel_valid (rel_valid),
    .i_rel_rd    (rel_rd),
    .i_rs1       (w_rs1),
    .i_rs2       (w_rs2),
    .o_rs1_busy  (w_rs1_busy),
    .o_rs2_busy  (w_rs2_busy)
  );

  assign w_hazard  = in_valid && ((w_uses_rs1 && w_rs1_busy) ||
                                  (w_uses_rs2 && w_rs2_busy));
  assign w_hold    = r_valid && ex_stall;
  assign stall_out = w_hazard || w_hold;

  // Flush refuses the beat even when it is otherwise acceptable, so the
  // scoreboard is only set for beats that really enter the pipeline.
  assign w_accept = in_valid && !w_hazard && !w_hold && !flush;
  assign w_set_en = w_accept && w_rd_write;

  // ---- bundle register: decode -> execute boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_class    <= CLASS_W'(CLS_ILLEGAL);
      r_funct3   <= '0;
      r_alt      <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rd_write <= 1'b0;
      r_imm      <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_hold) begin
      r_valid <= r_valid;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_pc       <= in_PC;
      r_class    <= CLASS_W'(w_class);
      r_funct3   <= in_instr[14:12];
      r_alt      <= w_alt;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_rd_write <= w_rd_write;
      r_imm      <= w_imm;
    end else begin
      r_valid <= 1'b0;
    end
  end

`ifdef SIMULATE
  always @(posedge clk) begin
    if (!reset && w_accept)
      $display("%0t decode: PC=%h class=%0d instr=%h", $time, in_PC, w_class, in_instr);
  end
`endif

  assign out_valid    = r_valid;
  assign out_PC       = r_pc;
  assign out_class    = r_class;
  assign out_funct3   = r_funct3;
  assign out_alt      = r_alt;
  assign out_rs1      = r_rs1;
  assign out_rs2      = r_rs2;
  assign out_rd       = r_rd;
  assign out_rd_write = r_rd_write;
  assign out_imm      = r_imm;

endmodule

// File: tb/tb_decode.sv
module tb_decode;

  logic        clk;
  logic        reset;
  logic [31:0] in_instr;
  logic [31:0] in_PC;
  logic        in_valid;
  logic        stall_out;
  logic        flush;
  logic        ex_stall;
  logic        out_valid;
  logic [31:0] out_PC;
  logic [3:0]  out_class;
  logic [2:0]  out_funct3;
  logic        out_alt;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_rd_write;
  logic [31:0] out_imm;
  logic        rel_valid;
  logic [4:0]  rel_rd;

  decode dut (
    .clk          (clk),
    .reset        (reset),
    .in_instr     (in_instr),
    .in_PC        (in_PC),
    .in_valid     (in_valid),
    .stall_out    (stall_out),
    .flush        (flush),
    .ex_stall     (ex_stall),
    .out_valid    (out_valid),
    .out_PC       (out_PC),
    .out_class    (out_class),
    .out_funct3   (out_funct3),
    .out_alt      (out_alt),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_rd_write (out_rd_write),
    .out_imm      (out_imm),
    .rel_valid    (rel_valid),
    .rel_rd       (rel_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rdw;
    logic [31:0] imm;
  } bundle_t;

  bundle_t exp_q[$];
  bundle_t last_exp;
  bundle_t got;
  bundle_t want;
  int checks = 0;
  int errors = 0;

  function automatic bundle_t mk(input logic [31:0] pc, input logic [3:0] cls,
                                 input logic [2:0] f3, input logic alt,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic rdw,
                                 input logic [31:0] imm);
    bundle_t b;
    b.pc = pc; b.cls = cls; b.f3 = f3; b.alt = alt;
    b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.rdw = rdw; b.imm = imm;
    return b;
  endfunction

  function automatic bundle_t obs();
    bundle_t b;
    b.pc = out_PC; b.cls = out_class; b.f3 = out_funct3; b.alt = out_alt;
    b.rs1 = out_rs1; b.rs2 = out_rs2; b.rd = out_rd; b.rdw = out_rd_write;
    b.imm = out_imm;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    in_instr = instr;
    in_PC    = pc;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_instr = '0; in_PC = '0; in_valid = 1'b0;
    flush = 1'b0; ex_stall = 1'b0; rel_valid = 1'b0; rel_rd = '0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_class !== 4'd15 || out_PC !== 32'd0 ||
        out_imm !== 32'd0 || out_rd_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got valid=%b class=%0d pc=%h imm=%h rdw=%b exp 0/15/0/0/0",
               out_valid, out_class, out_PC, out_imm, out_rd_write);
    end
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got %b exp 0", stall_out);
    end
  endtask

  task automatic test_basic_capture();
    present(32'h00500093, 32'd0);
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL addi_stall got %b exp 0", stall_out);
    end
    exp_q.push_back(mk(32'd0, 4'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5));
    tick();
    in_valid = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL addi_bundle got empty queue exp entry");
    end else begin
      want = exp_q.pop_front();
      last_exp = want;
      got = obs();
      if (out_valid !== 1'b1 || got !== want) begin
        errors++;
        $display("FAIL addi_bundle got v=%b %h exp v=1 %h", out_valid, got, want);
      end
    end
  endtask

  task automatic test_raw_hazard();
    present(32'h00108133, 32'd4);
    #1;
    checks++;
    if (stall_out !== 1'b1) begin
      errors++;
      $display("FAIL raw_stall_initial got %b exp 1", stall_out);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || stall_out !== 1'b1) begin
        errors++;
        $display("FAIL raw_bubble%0d got valid=%b stall=%b exp valid=0 stall=1",
                 i, out_valid, stall_out);
      end
    end
    rel_valid = 1'b1; rel_rd = 5'd1;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL raw_release_bypass got %b exp 0", stall_out);
    end
    exp_q.push_back(mk(32'd4, 4'd8, 3'd0, 1'b0, 5'd1, 5'd1, 5'd2, 1'b1, 32'd0));
    tick();
    rel_valid = 1'b0; in_valid = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL add_bundle got empty queue exp entry");
    end else begin
      want = exp_q.pop_front();
      last_exp = want;
      got = obs();
      if (out_valid !== 1'b1 || got !== want) begin
        errors++;
        $display("FAIL add_bundle got v=%b %h exp v=1 %h", out_valid, got, want);
      end
    end
  endtask

  task automatic test_hold();
    ex_stall = 1'b1;
    present(32'h00300193, 32'd8);
    #1;
    checks++;
    if (stall_out !== 1'b1) begin
      errors++;
      $display("FAIL hold_stall got %b exp 1", stall_out);
    end
    tick();
    got = obs();
    checks++;
    if (out_valid !== 1'b1 || got !== last_exp) begin
      errors++;
      $display("FAIL hold_bundle got v=%b %h exp v=1 %h", out_valid, got, last_exp);
    end
    ex_stall = 1'b0;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_release_stall got %b exp 0", stall_out);
    end
    exp_q.push_back(mk(32'd8, 4'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 32'd3));
    tick();
    in_valid = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL hold_capture got empty queue exp entry");
    end else begin
      want = exp_q.pop_front();
      last_exp = want;
      got = obs();
      if (out_valid !== 1'b1 || got !== want) begin
        errors++;
        $display("FAIL hold_capture got v=%b %h exp v=1 %h", out_valid, got, want);
      end
    end
  endtask

  task automatic test_flush();
    present(32'hfe000ee3, 32'd12);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_beq_valid got %b exp 0", out_valid);
    end
    // A flushed writer must not leave its rd busy.
    present(32'h00400213, 32'd16);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_addi_valid got %b exp 0", out_valid);
    end
    present(32'h000202b3, 32'd20);
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_busy_set got stall=%b exp 0", stall_out);
    end
    exp_q.push_back(mk(32'd20, 4'd8, 3'd0, 1'b0, 5'd4, 5'd0, 5'd5, 1'b1, 32'd0));
    tick();
    present(32'hfff00513, 32'd24);
    exp_q.push_back(mk(32'd24, 4'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd10, 1'b1, 32'hffffffff));
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL after_flush_add got empty queue exp entry");
    end else begin
      want = exp_q.pop_front();
      got = obs();
      if (out_valid !== 1'b1 || got !== want) begin
        errors++;
        $display("FAIL after_flush_add got v=%b %h exp v=1 %h", out_valid, got, want);
      end
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL addi_neg1 got empty queue exp entry");
    end else begin
      want = exp_q.pop_front();
      got = obs();
      if (out_valid !== 1'b1 || got !== want) begin
        errors++;
        $display("FAIL addi_neg1 got v=%b %h exp v=1 %h", out_valid, got, want);
      end
    end
  endtask

  task automatic test_back_to_back_formats();
    logic [31:0] instrs [6];
    bundle_t     exps   [6];
    instrs[0] = 32'h00000000;
    exps[0]   = mk(32'd28, 4'd15, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    instrs[1] = 32'h0000007f;
    exps[1]   = mk(32'd32, 4'd15, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    instrs[2] = 32'h123452b7;
    exps[2]   = mk(32'd36, 4'd0, 3'd5, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 32'h12345000);
    instrs[3] = 32'hffdff06f;
    exps[3]   = mk(32'd40, 4'd2, 3'd7, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'hfffffffc);
    instrs[4] = 32'hfe002c23;
    exps[4]   = mk(32'd44, 4'd6, 3'd2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'hfffffff8);
    instrs[5] = 32'h40305313;
    exps[5]   = mk(32'd48, 4'd7, 3'd5, 1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 32'h00000403);
    for (int i = 0; i < 6; i++) begin
      present(instrs[i], 32'd28 + 32'(i) * 32'd4);
      exp_q.push_back(exps[i]);
      tick();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL format%0d got empty queue exp entry", i);
      end else begin
        want = exp_q.pop_front();
        got = obs();
        if (out_valid !== 1'b1 || got !== want) begin
          errors++;
          $display("FAIL format%0d got v=%b %h exp v=1 %h", i, out_valid, got, want);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    // x3 is still busy from the held-beat scenario; out_valid is 1.
    present(32'h00018233, 32'd52);
    #1;
    checks++;
    if (stall_out !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state got stall=%b valid=%b exp 1/1", stall_out, out_valid);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_class !== 4'd15 || out_PC !== 32'd0 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got valid=%b class=%0d pc=%h stall=%b exp 0/15/0/0",
               out_valid, out_class, out_PC, stall_out);
    end
    tick();
    reset = 1'b0;
    exp_q.push_back(mk(32'd52, 4'd8, 3'd0, 1'b0, 5'd3, 5'd0, 5'd4, 1'b1, 32'd0));
    tick();
    in_valid = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL post_reset_capture got empty queue exp entry");
    end else begin
      want = exp_q.pop_front();
      got = obs();
      if (out_valid !== 1'b1 || got !== want) begin
        errors++;
        $display("FAIL post_reset_capture got v=%b %h exp v=1 %h", out_valid, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_raw_hazard();
    test_hold();
    test_flush();
    test_back_to_back_formats();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
